// File: rtl/mem_responder.sv
// Single-port word memory with byte-lane writes and a fixed-latency read pipeline.
// Optional MEM_RESP_ERR_EN adds an error pulse for bad, misaligned or conflicting requests.
module mem_responder #(
    parameter int unsigned DEPTH        = 256,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [31:0] write_data,
    input  logic [3:0]  byte_enables,
    output logic [31:0] read_data,
    output logic        read_valid
`ifdef MEM_RESP_ERR_EN
    ,
    output logic        error
`endif
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

    logic [31:0]   w_offset;
    logic          w_in_range;
    logic [AW-1:0] w_index;
    logic          w_rd_req;
    logic          w_wr_req;

    assign w_offset   = address - BASE_ADDR;
    assign w_in_range = (address >= BASE_ADDR) && ({1'b0, w_offset} < SPAN);
    assign w_index    = w_offset[AW+1:2];
    // A simultaneous read and write is treated as a write only.
    assign w_wr_req   = write_enable;
    assign w_rd_req   = read_enable && !write_enable;

    logic w_unused;
    assign w_unused = &{1'b0, w_offset[31:AW+2], w_offset[1:0]};

    logic [31:0] r_mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM and survives rst;
    // the write is still gated by rst so requests during reset are ignored.
    always_ff @(posedge clk) begin
        if (rst && w_wr_req && w_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_enables[i]) begin
                    r_mem[w_index][8*i +: 8] <= write_data[8*i +: 8];
                end
            end
        end
    end

    logic [READ_LATENCY-1:0] r_pipe_vld;
    logic [31:0]             r_pipe_data [READ_LATENCY];

    // NOTE: non-blocking assignments make stage 0 sample the pre-write memory
    // contents and let every stage shift from its neighbour's old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pipe_vld <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                r_pipe_data[k] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_rd_req;
            if (w_rd_req) begin
                r_pipe_data[0] <= w_in_range ? r_mem[w_index] : 32'h0000_0000;
            end
            // Data only moves with a valid token, so the last stage holds between reads.
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_pipe_vld[k] <= r_pipe_vld[k-1];
                if (r_pipe_vld[k-1]) begin
                    r_pipe_data[k] <= r_pipe_data[k-1];
                end
            end
        end
    end

    assign read_valid = r_pipe_vld[READ_LATENCY-1];
    assign read_data  = r_pipe_data[READ_LATENCY-1];

`ifdef MEM_RESP_ERR_EN
    logic                    w_addr_bad;
    logic [READ_LATENCY-1:0] r_pipe_err;
    logic                    r_wr_err;

    assign w_addr_bad = !w_in_range || (address[1:0] != 2'b00);

    // Read errors ride the read pipeline; write errors report one cycle after the request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pipe_err <= '0;
            r_wr_err   <= 1'b0;
        end else begin
            r_pipe_err[0] <= w_rd_req && w_addr_bad;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_pipe_err[k] <= r_pipe_err[k-1];
            end
            r_wr_err <= w_wr_req && (w_addr_bad || read_enable);
        end
    end

    assign error = r_wr_err | (read_valid & r_pipe_err[READ_LATENCY-1]);
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: reads push expected data/timing, a negedge monitor pops and compares.
module tb_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;
    localparam int AW    = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] address = '0;
    logic        read_enable = 1'b0;
    logic        write_enable = 1'b0;
    logic [31:0] write_data = '0;
    logic [3:0]  byte_enables = '0;
    logic [31:0] read_data;
    logic        read_valid;
`ifdef MEM_RESP_ERR_EN
    logic        error;
`endif

    mem_responder #(
        .DEPTH(DEPTH),
        .BASE_ADDR(32'h0000_0000),
        .READ_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .address(address),
        .read_enable(read_enable),
        .write_enable(write_enable),
        .write_data(write_data),
        .byte_enables(byte_enables),
        .read_data(read_data),
        .read_valid(read_valid)
`ifdef MEM_RESP_ERR_EN
        ,
        .error(error)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          wr_err_q[$];
    logic [31:0] model [DEPTH];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_checks = 0;
    logic [31:0] last_data = '0;
    bit          mon_en = 1'b0;
    exp_t        mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return a < 32'(DEPTH * 4);
    endfunction

    // One request per call, driven just after a rising edge; model and scoreboard follow.
    task automatic req(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
        exp_t e;
        @(posedge clk); #1;
        read_enable  = rd;
        write_enable = wr;
        address      = a;
        write_data   = d;
        byte_enables = be;
        if (rst) begin
            if (rd && !wr) begin
                e.data = in_rng(a) ? model[a[AW+1:2]] : 32'h0;
                e.due  = cyc + LAT;
                e.err  = !in_rng(a) || (a[1:0] != 2'b00);
                sb.push_back(e);
            end
            if (wr && in_rng(a)) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) model[a[AW+1:2]][8*i +: 8] = d[8*i +: 8];
            end
            if (wr && (!in_rng(a) || (a[1:0] != 2'b00) || rd)) wr_err_q.push_back(cyc + 1);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        read_enable  = 1'b0;
        write_enable = 1'b0;
    endtask

    task automatic assert_reset();
        @(posedge clk); #1;
        rst          = 1'b0;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        sb.delete();
        wr_err_q.delete();
        last_data = '0;
        #1;
        check("rst_valid", 32'(read_valid), 32'h0);
        check("rst_data", read_data, 32'h0);
`ifdef MEM_RESP_ERR_EN
        check("rst_error", 32'(error), 32'h0);
`endif
    endtask

    // Release mid-cycle with a read already presented: it must be taken on the first live edge.
    task automatic release_reset_with_read(input logic [31:0] a);
        exp_t e;
        @(negedge clk); #1;
        rst          = 1'b1;
        read_enable  = 1'b1;
        write_enable = 1'b0;
        address      = a;
        e.data = in_rng(a) ? model[a[AW+1:2]] : 32'h0;
        e.due  = cyc + LAT;
        e.err  = !in_rng(a) || (a[1:0] != 2'b00);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_en && rst) begin
`ifdef MEM_RESP_ERR_EN
            logic exp_err;
            exp_err = 1'b0;
`endif
            if (read_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", 32'(read_valid), 32'h0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rd_data", read_data, mon_e.data);
                    check("rd_time", 32'(cyc), 32'(mon_e.due));
`ifdef MEM_RESP_ERR_EN
                    exp_err = mon_e.err;
`endif
                end
                last_data = read_data;
            end else begin
                check("hold", read_data, last_data);
                if (sb.size() > 0 && sb[0].due < cyc) begin
                    check("missing_valid", 32'(cyc), 32'(sb[0].due));
                    void'(sb.pop_front());
                end
            end
`ifdef MEM_RESP_ERR_EN
            if (wr_err_q.size() > 0 && wr_err_q[0] == cyc) begin
                exp_err = 1'b1;
                void'(wr_err_q.pop_front());
            end
            check("error", 32'(error), 32'(exp_err));
`endif
        end
    end

    initial begin
        logic [31:0] a;
        int op;

        // Asynchronous clear before any clock edge has occurred.
        #3 rst = 1'b0;
        #1;
        check("rst_valid", 32'(read_valid), 32'h0);
        check("rst_data", read_data, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst    = 1'b1;
        mon_en = 1'b1;

        // Full-word write then read, then partial lanes, then an all-lanes-off write.
        req(0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
        req(1, 0, 32'h10, 32'h0, 4'h0);
        req(0, 1, 32'h10, 32'h11223344, 4'b0101);
        req(1, 0, 32'h10, 32'h0, 4'h0);
        req(0, 1, 32'h10, 32'hFFFFFFFF, 4'b0000);
        req(1, 0, 32'h10, 32'h0, 4'h0);
        idle();

        // Back-to-back reads come back back-to-back and in order.
        req(0, 1, 32'h0, 32'd1, 4'hF);
        req(0, 1, 32'h4, 32'd2, 4'hF);
        req(0, 1, 32'h8, 32'd3, 4'hF);
        req(1, 0, 32'h0, 32'h0, 4'h0);
        req(1, 0, 32'h4, 32'h0, 4'h0);
        req(1, 0, 32'h8, 32'h0, 4'h0);
        idle();

        // Out-of-range read returns zero; out-of-range writes must not alias onto any word.
        req(1, 0, 32'h400, 32'h0, 4'h0);
        req(0, 1, 32'h400, 32'hCAFEF00D, 4'hF);
        req(0, 1, 32'hFFFFFFFC, 32'h0BADBAD0, 4'hF);
        req(1, 0, 32'h0, 32'h0, 4'h0);
        req(1, 0, 32'h4, 32'h0, 4'h0);
        req(1, 0, 32'h8, 32'h0, 4'h0);
        req(1, 0, 32'h10, 32'h0, 4'h0);

        // Last word, and low address bits ignored for indexing.
        req(0, 1, 32'h3FC, 32'h55AA55AA, 4'hF);
        req(1, 0, 32'h3FF, 32'h0, 4'h0);
        req(1, 0, 32'h11, 32'h0, 4'h0);
        idle();

        // Read and write together: write only, no response.
        req(1, 1, 32'h20, 32'hA5A5A5A5, 4'hF);
        idle();
        req(1, 0, 32'h20, 32'h0, 4'h0);
        idle();

        // Reset with a read in flight; a write during reset must be ignored.
        req(0, 1, 32'h30, 32'h12345678, 4'hF);
        req(1, 0, 32'h10, 32'h0, 4'h0);
        assert_reset();
        req(0, 1, 32'h30, 32'h00000BAD, 4'hF);
        idle();
        release_reset_with_read(32'h30);
        req(1, 0, 32'h10, 32'h0, 4'h0);
        idle();

        // Random mixed traffic over a small window with occasional bad addresses.
        for (int i = 0; i < 16; i++) req(0, 1, 32'(i * 4), $urandom, 4'hF);
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 9);
            a  = 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) a = a + 32'h400;
            if (op < 2)       idle();
            else if (op < 5)  req(1, 0, a, 32'h0, 4'h0);
            else if (op < 9)  req(0, 1, a, $urandom, 4'($urandom_range(0, 15)));
            else              req(1, 1, a, $urandom, 4'($urandom_range(0, 15)));
        end
        idle();

        repeat (LAT + 3) @(posedge clk);
        @(negedge clk); #1;
        check("drain", 32'(sb.size()), 32'h0);
`ifdef MEM_RESP_ERR_EN
        check("drain_err", 32'(wr_err_q.size()), 32'h0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
